// File: rtl/par_ser_tx_if.sv
// Parallel-in / serial-out transmitter bus: byte and load request in, line and status out.
// No timing of its own; master drives qin/load, slave drives sout/busy/done.
// Backpressure: busy high means load is ignored by the slave.
interface par_ser_tx_if;
    logic [7:0] qin;
    logic       load;
    logic       sout;
    logic       busy;
    logic       done;

    modport master (
        output qin,
        output load,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  qin,
        input  load,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/par_ser_tx.sv
// Byte serialiser: start, 8 data bits LSB first, optional even parity (PAR_SER_TX_PARITY_EN), stop.
// Latency: first line bit one cycle after load edge; frame is 10 (11) * CLKS_PER_BIT cycles.
// Backpressure: load ignored while busy; accepted again on the done cycle.
module par_ser_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    par_ser_tx_if.slave bus
);
    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 255) begin : g_bad_cpb
        $error("par_ser_tx: CLKS_PER_BIT out of range 1..255");
    end

`ifdef PAR_SER_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_nxt;
    logic [7:0] shreg, sh_nxt;
    logic       sout_q, sout_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       wrap;
`ifdef PAR_SER_TX_PARITY_EN
    logic       par_q, par_nxt;
`endif

    assign wrap     = (cnt == CNT_MAX);
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PAR_SER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            sout_q  <= sout_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
`ifdef PAR_SER_TX_PARITY_EN
            par_q   <= par_nxt;
`endif
        end
    end

    // Outputs are computed as next-state values so the line changes on the
    // same edge as the state, keeping every bit exactly CLKS_PER_BIT long.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        sout_nxt  = sout_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
`ifdef PAR_SER_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            IDLE: begin
                cnt_nxt  = 8'd0;
                sout_nxt = 1'b1;
                busy_nxt = 1'b0;
                if (bus.load) begin
                    sh_nxt    = bus.qin;
                    state_nxt = START;
                    sout_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef PAR_SER_TX_PARITY_EN
                    par_nxt   = ^bus.qin;
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_nxt = DATA;
                    cnt_nxt   = 8'd0;
                    sout_nxt  = shreg[0];
                    sh_nxt    = {1'b0, shreg[7:1]};
                end
            end
            DATA: begin
                if (wrap) begin
                    cnt_nxt = 8'd0;
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef PAR_SER_TX_PARITY_EN
                        state_nxt = PARITY;
                        sout_nxt  = par_q;
`else
                        state_nxt = STOP;
                        sout_nxt  = 1'b1;
`endif
                    end else begin
                        sout_nxt = shreg[0];
                        sh_nxt   = {1'b0, shreg[7:1]};
                    end
                end
            end
`ifdef PAR_SER_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_nxt = STOP;
                    cnt_nxt   = 8'd0;
                    sout_nxt  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                    sout_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
                sout_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_par_ser_tx.sv
// Directed bench for par_ser_tx at CLKS_PER_BIT=4; follows PAR_SER_TX_PARITY_EN if defined.
module tb_par_ser_tx;
    localparam int CPB = 4;
`ifdef PAR_SER_TX_PARITY_EN
    localparam int NB     = 11;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int NB     = 10;
    localparam bit PAR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    par_ser_tx_if bus();
    par_ser_tx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_chk  = 0;
    int n_pass = 0;

    // mode 0: plain frame; 1: qin/load disturbed mid-DATA; 2: hold load with qin=0x42
    typedef struct {
        logic [7:0] data;
        logic       par;
        int         mode;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] outs();
        return {5'd0, bus.sout, bus.busy, bus.done};
    endfunction

    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PAR_ON && idx == 9) return p;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge sampling the done cycle.
    task automatic play(input logic [7:0] d, input logic p, input bit do_load, input int mode);
        if (do_load) begin
            bus.qin  = d;
            bus.load = 1'b1;
            @(negedge clk);
        end
        if (mode == 2) begin
            bus.load = 1'b1;
            bus.qin  = 8'h42;
        end else begin
            bus.load = 1'b0;
            bus.qin  = ~d;
        end
        for (int k = 0; k < NB*CPB; k++) begin
            check($sformatf("frame %02h bit %0d cyc %0d", d, k/CPB, k),
                  outs(), {5'd0, exp_bit(d, p, k/CPB), 1'b1, 1'b0});
            if (mode == 1 && k == 3*CPB) begin
                bus.load = 1'b1;
                bus.qin  = 8'hFF;
            end
            if (mode == 1 && k == 3*CPB + 1) bus.load = 1'b0;
            @(negedge clk);
        end
        check($sformatf("frame %02h done cycle", d), outs(), 8'h05);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs = '{'{8'hA5, 1'b0, 0}, '{8'h07, 1'b1, 0}, '{8'h00, 1'b0, 0},
                 '{8'hFF, 1'b0, 0}, '{8'h3C, 1'b0, 1}, '{8'h80, 1'b1, 0}};
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.qin  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset outputs", outs(), 8'h04);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle after reset %0d", i), outs(), 8'h04);
        end

        for (int v = 0; v < 6; v++) begin
            play(vecs[v].data, vecs[v].par, 1'b1, vecs[v].mode);
            @(negedge clk);
            check($sformatf("idle after %02h", vecs[v].data), outs(), 8'h04);
            if (vecs[v].mode == 1) begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check($sformatf("no second frame %0d", i), outs(), 8'h04);
                end
            end
        end

        // back-to-back: 0x42 is captured on the edge ending the done cycle
        play(8'h81, 1'b0, 1'b1, 2);
        @(negedge clk);
        bus.load = 1'b0;
        play(8'h42, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("idle after back-to-back", outs(), 8'h04);

        // asynchronous reset in the middle of DATA, between clock edges
        bus.qin  = 8'h55;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2*CPB + 2) @(negedge clk);
        check("pre-reset mid DATA busy", outs() & 8'h02, 8'h02);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset immediate", outs(), 8'h04);
        @(negedge clk);
        check("async reset held", outs(), 8'h04);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("idle after mid-frame reset %0d", i), outs(), 8'h04);
        end
        play(8'h01, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("idle after final frame", outs(), 8'h04);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
